// File: rtl/time_pkg.sv
// Shared constants, state encoding and divisor lookup for the serial
// millisecond-to-time converter.
package time_pkg;

    localparam int unsigned MS_PER_DAY  = 86_400_000;
    localparam int unsigned MS_PER_HOUR = 3_600_000;
    localparam int unsigned MS_PER_MIN  = 60_000;
    localparam int unsigned MS_PER_SEC  = 1_000;

    // Widest divisor (86,400,000) needs 27 bits.
    localparam int DIVR_W = 27;

    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int MSF_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [DIVR_W-1:0] stage_divisor(input logic [1:0] stage);
        case (stage)
            2'd0:    return DIVR_W'(MS_PER_DAY);
            2'd1:    return DIVR_W'(MS_PER_HOUR);
            2'd2:    return DIVR_W'(MS_PER_MIN);
            default: return DIVR_W'(MS_PER_SEC);
        endcase
    endfunction

endpackage

// File: rtl/serial_const_div.sv
// Restoring divider producing one quotient bit per enabled cycle, MSB first.
// On the last bit it reloads its own remainder as the next dividend so stages chain back to back.
module serial_const_div
    import time_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              sub_en_i,
    input  logic [IN_W-1:0]   dividend_i,
    input  logic [DIVR_W-1:0] divisor_i,
    output logic              done_o,
    output logic [IN_W-1:0]   quot_o,
    output logic [IN_W-1:0]   rem_o
);

    localparam int CW    = (IN_W + 1 > DIVR_W) ? IN_W + 1 : DIVR_W;
    localparam int CNT_W = $clog2(IN_W);

    logic [IN_W-1:0]  dvd_q;
    logic [IN_W-1:0]  rem_q;
    logic [IN_W-2:0]  quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IN_W:0]    part_rem;
    logic             take;
    logic [IN_W-1:0]  rem_d;
    logic [IN_W-1:0]  quo_d;

    // Remainder stays below the divisor (or below the dividend prefix when
    // subtraction is disabled), so IN_W bits hold it between steps.
    always_comb begin
        part_rem = {rem_q, dvd_q[IN_W-1]};
        take     = sub_en_i && (CW'(part_rem) >= CW'(divisor_i));
        rem_d    = take ? IN_W'(CW'(part_rem) - CW'(divisor_i)) : part_rem[IN_W-1:0];
        quo_d    = {quo_q, take};
    end

    assign done_o = en_i && (cnt_q == '0);
    assign quot_o = quo_d;
    assign rem_o  = rem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            dvd_q <= dividend_i;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CNT_W'(IN_W - 1);
        end else if (en_i) begin
            if (cnt_q == '0) begin
                dvd_q <= rem_d;
                rem_q <= '0;
                quo_q <= '0;
                cnt_q <= CNT_W'(IN_W - 1);
            end else begin
                dvd_q <= dvd_q << 1;
                rem_q <= rem_d;
                quo_q <= quo_d[IN_W-2:0];
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ms_to_time_serial.sv
// Serial millisecond-to-time converter: four chained divide stages on a shared
// divider, then one cycle to saturate and register the result.
module ms_to_time_serial
    import time_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DAY_W  = 8,
    parameter int HOUR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_ms,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DAY_W-1:0]  out_days,
    output logic [HOUR_W-1:0] out_hours,
    output logic [MIN_W-1:0]  out_min,
    output logic [SEC_W-1:0]  out_sec,
    output logic [MSF_W-1:0]  out_ms,
    output logic              out_ovf
);

    state_e             state_q;
    logic [2:0]         stage_q;
    logic               mode_q;
    logic [IN_W-1:0]    day_quo_q;
    logic [IN_W-1:0]    hour_quo_q;
    logic [MIN_W-1:0]   min_quo_q;
    logic [SEC_W-1:0]   sec_quo_q;
    logic [MSF_W-1:0]   ms_rem_q;

    logic               out_valid_q;
    logic [DAY_W-1:0]   out_days_q;
    logic [HOUR_W-1:0]  out_hours_q;
    logic [MIN_W-1:0]   out_min_q;
    logic [SEC_W-1:0]   out_sec_q;
    logic [MSF_W-1:0]   out_ms_q;
    logic               out_ovf_q;

    logic               div_load;
    logic               div_en;
    logic               div_done;
    logic [IN_W-1:0]    div_quot;
    logic [IN_W-1:0]    div_rem;

    logic               day_ovf;
    logic               hour_ovf;
    logic [DAY_W-1:0]   days_d;
    logic [HOUR_W-1:0]  hours_d;

    assign div_load = (state_q == IDLE) && in_valid && !clr;
    // Stage 4 is the result-register cycle; the divider idles there.
    assign div_en   = (state_q == DIV) && !stage_q[2] && !clr;

    serial_const_div #(
        .IN_W(IN_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (div_load),
        .en_i       (div_en),
        .sub_en_i   (!(mode_q && (stage_q == 3'd0))),
        .dividend_i (in_ms),
        .divisor_i  (stage_divisor(stage_q[1:0])),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_comb begin
        day_ovf  = |(day_quo_q >> DAY_W);
        hour_ovf = mode_q && (|(hour_quo_q >> HOUR_W));
        days_d   = day_ovf  ? '1 : DAY_W'(day_quo_q);
        hours_d  = hour_ovf ? '1 : HOUR_W'(hour_quo_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            mode_q      <= 1'b0;
            day_quo_q   <= '0;
            hour_quo_q  <= '0;
            min_quo_q   <= '0;
            sec_quo_q   <= '0;
            ms_rem_q    <= '0;
            out_valid_q <= 1'b0;
            out_days_q  <= '0;
            out_hours_q <= '0;
            out_min_q   <= '0;
            out_sec_q   <= '0;
            out_ms_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mode_q  <= in_mode;
                        stage_q <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    if (stage_q[2]) begin
                        out_days_q  <= days_d;
                        out_hours_q <= hours_d;
                        out_min_q   <= min_quo_q;
                        out_sec_q   <= sec_quo_q;
                        out_ms_q    <= ms_rem_q;
                        out_ovf_q   <= day_ovf || hour_ovf;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (div_done) begin
                        case (stage_q[1:0])
                            2'd0: day_quo_q  <= div_quot;
                            2'd1: hour_quo_q <= div_quot;
                            2'd2: min_quo_q  <= MIN_W'(div_quot);
                            default: begin
                                sec_quo_q <= SEC_W'(div_quot);
                                ms_rem_q  <= MSF_W'(div_rem);
                            end
                        endcase
                        stage_q <= stage_q + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_days  = out_days_q;
    assign out_hours = out_hours_q;
    assign out_min   = out_min_q;
    assign out_sec   = out_sec_q;
    assign out_ms    = out_ms_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ms_to_time_serial.sv
// Directed bench for ms_to_time_serial: scoreboard of expected conversions
// against a default instance and a DAY_W=4 instance sharing the same stimulus.
module tb_ms_to_time_serial;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, in_valid, in_mode, out_ready;
    logic [31:0] in_ms;

    logic        in_ready, out_valid, out_ovf;
    logic [7:0]  out_days;
    logic [15:0] out_hours;
    logic [5:0]  out_min, out_sec;
    logic [9:0]  out_ms;

    logic        in_ready4, out_valid4, out_ovf4;
    logic [3:0]  out_days4;
    logic [15:0] out_hours4;
    logic [5:0]  out_min4, out_sec4;
    logic [9:0]  out_ms4;

    ms_to_time_serial #(.IN_W(32), .DAY_W(8), .HOUR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_ms(in_ms), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_days(out_days), .out_hours(out_hours), .out_min(out_min), .out_sec(out_sec),
        .out_ms(out_ms), .out_ovf(out_ovf)
    );

    ms_to_time_serial #(.IN_W(32), .DAY_W(4), .HOUR_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
        .in_ms(in_ms), .in_mode(in_mode), .out_valid(out_valid4), .out_ready(out_ready),
        .out_days(out_days4), .out_hours(out_hours4), .out_min(out_min4), .out_sec(out_sec4),
        .out_ms(out_ms4), .out_ovf(out_ovf4)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic [9:0]  ms;
        logic        ovf;
        logic [3:0]  d4;
        logic        ovf4;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t model(input logic [31:0] v, input logic md);
        exp_t e;
        longint unsigned x, d, h, m, s;
        x = longint'(v);
        d = md ? 0 : x / 86400000;
        if (!md) x = x % 86400000;
        h = x / 3600000;  x = x % 3600000;
        m = x / 60000;    x = x % 60000;
        s = x / 1000;     x = x % 1000;
        e.d    = (d > 255) ? 8'hFF : 8'(d);
        e.d4   = (d > 15) ? 4'hF : 4'(d);
        e.h    = (h > 65535) ? 16'hFFFF : 16'(h);
        e.m    = 6'(m);
        e.s    = 6'(s);
        e.ms   = 10'(x);
        e.ovf  = (d > 255) || (h > 65535);
        e.ovf4 = (d > 15) || (h > 65535);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] v, input logic md);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin step(); n++; end
        chk("ready_before_accept", in_ready, 1);
        in_ms = v; in_mode = md; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("busy_after_accept", in_ready, 0);
    endtask

    task automatic convert(input logic [31:0] v, input logic md, input int hold);
        int   n;
        exp_t e;
        sb.push_back(model(v, md));
        accept(v, md);
        n = 0;
        while (!out_valid && n < 300) begin step(); n++; end
        chk("latency", n, 129);
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            if (hold > 0) begin
                in_ms = 32'h1234_5678; in_mode = ~md; in_valid = 1'b1;
                for (int i = 0; i < hold; i++) begin
                    step();
                    chk("held_state", {out_valid, in_ready, out_days, out_hours, out_min, out_sec, out_ms},
                        {1'b1, 1'b0, e.d, e.h, e.m, e.s, e.ms});
                end
                in_valid = 1'b0;
            end
            chk("days", out_days, e.d);
            chk("hours", out_hours, e.h);
            chk("min", out_min, e.m);
            chk("sec", out_sec, e.s);
            chk("ms", out_ms, e.ms);
            chk("ovf", out_ovf, e.ovf);
            chk("days_w4", out_days4, e.d4);
            chk("ovf_w4", out_ovf4, e.ovf4);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("consumed", out_valid, 0);
            chk("ready_after_consume", in_ready, 1);
            chk("retain_ms", out_ms, e.ms);
            if (hold > 0) begin
                repeat (3) step();
                chk("ignored_request_not_queued", {in_ready, out_valid}, {1'b1, 1'b0});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0; in_ms = '0;
        step(); step();
        chk("reset_ready", in_ready, 1);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", {out_days, out_hours, out_min, out_sec, out_ms, out_ovf}, 0);
        rst_n = 1'b1;
        step();

        convert(32'd3_723_004, 1'b0, 0);
        convert(32'd90_061_001, 1'b0, 0);
        convert(32'd90_061_001, 1'b1, 0);
        convert(32'd86_399_999, 1'b0, 0);
        convert(32'd0, 1'b0, 0);
        convert(32'd3_723_004, 1'b0, 20);

        // clr alongside in_valid in IDLE must not start a conversion
        clr = 1'b1; in_valid = 1'b1; in_ms = 32'd5000;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_idle_no_accept", in_ready, 1);

        convert(32'hFFFF_FFFF, 1'b0, 0);

        // Abort via clr partway through the divide
        accept(32'd3_723_004, 1'b0);
        repeat (49) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ready", in_ready, 1);
        chk("clr_valid", out_valid, 0);
        chk("clr_ovf_w4", out_ovf4, 0);
        seen = 1'b0;
        repeat (150) begin step(); seen = seen | out_valid; end
        chk("clr_no_late_valid", seen, 0);

        // Asynchronous reset partway through the divide
        accept(32'd90_061_001, 1'b0);
        repeat (30) step();
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", {out_days, out_hours, out_min, out_sec, out_ms, out_ovf}, 0);
        step();
        rst_n = 1'b1;
        step();

        convert(32'd3_723_004, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            convert($urandom, 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
